rtc_bus_writer: RTL

RTC_BUS_WRITER -- requirements
Module: rtc_bus_writer

---
 rtl/rtc_bus_writer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_writer
// Brief    : Multiplexed AD-bus master for an RTC: address/ALE, strobe, hold.
//            Optional macro RTC_READ_EN enables full read transactions.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_writer #(
  parameter int T_ALE  = 4,
  parameter int T_CMD  = 8,
  parameter int T_HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       req,
  input  logic       a_d,
  input  logic       w_r,
  input  logic [7:0] dato_in,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ale,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] dato_out
);

  // Counter reload values; a zero parameter behaves as one cycle.
  localparam logic [7:0] c_ale_ld  = 8'((T_ALE  > 1) ? T_ALE  - 1 : 0);
  localparam logic [7:0] c_cmd_ld  = 8'((T_CMD  > 1) ? T_CMD  - 1 : 0);
  localparam logic [7:0] c_hold_ld = 8'((T_HOLD > 1) ? T_HOLD - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALE  = 3'd1,
    S_CMD  = 3'd2,
    S_HOLD = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_addr, r_data;
  logic       r_wr, r_addr_valid;
  logic       w_accept_addr, w_accept_data, w_go_cmd;

  logic [7:0] r_ad_out, w_ad_out;
  logic       r_ad_oe, w_ad_oe;
  logic       r_cs_n, w_cs_n;
  logic       r_ale, w_ale;
  logic       r_wr_n, w_wr_n;
  logic       r_rd_n, w_rd_n;
  logic       r_busy, w_busy;
  logic       r_done, w_done;

`ifdef RTC_READ_EN
  assign w_go_cmd = 1'b1;
`else
  // Without read support a read request only performs the address phase.
  assign w_go_cmd = r_wr;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept_addr = 1'b0;
    w_accept_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req && !a_d) begin
          w_accept_addr = 1'b1;
        end else if (req && a_d && r_addr_valid) begin
          w_accept_data = 1'b1;
          w_state_nxt   = S_ALE;
          w_cnt_nxt     = c_ale_ld;
        end
      end
      S_ALE: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (w_go_cmd) begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = c_cmd_ld;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      S_CMD: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_hold_ld;
        end
      end
      S_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = 8'd0;
      w_accept_addr = 1'b0;
      w_accept_data = 1'b0;
    end
  end

  // Bus pins are registered from the current state, so they trail it by one cycle.
  always_comb begin
    w_cs_n   = 1'b1;
    w_ale    = 1'b0;
    w_wr_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_ad_oe  = 1'b0;
    w_ad_out = 8'h00;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    if (enable) begin
      case (r_state)
        S_ALE: begin
          w_cs_n   = 1'b0;
          w_ale    = 1'b1;
          w_ad_oe  = 1'b1;
          w_ad_out = r_addr;
          w_busy   = 1'b1;
        end
        S_CMD: begin
          w_cs_n = 1'b0;
          w_busy = 1'b1;
          if (r_wr) begin
            w_wr_n   = 1'b0;
            w_ad_oe  = 1'b1;
            w_ad_out = r_data;
          end else begin
`ifdef RTC_READ_EN
            w_rd_n = 1'b0;
`endif
          end
        end
        S_HOLD: begin
          w_cs_n = 1'b0;
          w_busy = 1'b1;
          if (r_wr) begin
            w_ad_oe  = 1'b1;
            w_ad_out = r_data;
          end
        end
        S_FIN: begin
          w_done = 1'b1;
        end
        default: begin
          w_done = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_addr       <= 8'h00;
      r_data       <= 8'h00;
      r_wr         <= 1'b0;
      r_addr_valid <= 1'b0;
      r_ad_out     <= 8'h00;
      r_ad_oe      <= 1'b0;
      r_cs_n       <= 1'b1;
      r_ale        <= 1'b0;
      r_wr_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ad_out <= w_ad_out;
      r_ad_oe  <= w_ad_oe;
      r_cs_n   <= w_cs_n;
      r_ale    <= w_ale;
      r_wr_n   <= w_wr_n;
      r_rd_n   <= w_rd_n;
      r_busy   <= w_busy;
      r_done   <= w_done;
      if (w_accept_addr) begin
        r_addr <= dato_in;
      end
      if (w_accept_data) begin
        r_data <= dato_in;
        r_wr   <= w_r;
      end
      if (!enable) begin
        r_addr_valid <= 1'b0;
      end else if (w_accept_addr) begin
        r_addr_valid <= 1'b1;
      end else if (r_state == S_FIN) begin
        r_addr_valid <= 1'b0;
      end
    end
  end

`ifdef RTC_READ_EN
  logic [7:0] r_dato;

  // First HOLD state cycle is the last cycle rd_n is low on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dato <= 8'h00;
    end else if (enable && r_state == S_HOLD && !r_rd_n) begin
      r_dato <= ad_in;
    end
  end

  assign dato_out = r_dato;
`else
  logic w_unused_ad_in;
  assign w_unused_ad_in = ^ad_in;
  assign dato_out       = 8'h00;
`endif

  assign ad_out = r_ad_out;
  assign ad_oe  = r_ad_oe;
  assign cs_n   = r_cs_n;
  assign ale    = r_ale;
  assign wr_n   = r_wr_n;
  assign rd_n   = r_rd_n;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire
